// File: rtl/mem_access_ctrl_pkg.sv
// Shared encodings for the MEM-stage access controller: request types, FSM states, timeout default.
package mem_access_ctrl_pkg;

  typedef enum logic [2:0] {
    RT_WORD   = 3'd0,
    RT_BYTE_U = 3'd1,
    RT_BYTE_S = 3'd2,
    RT_HALF_U = 3'd3,
    RT_HALF_S = 3'd4
  } req_type_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  localparam int TIMEOUT_DEFAULT = 255;

  // Words must be 4-byte aligned, halves 2-byte aligned; codes 5-7 are never legal.
  function automatic logic type_legal(input logic [2:0] rtype, input logic [1:0] addr_lo);
    case (rtype)
      RT_WORD:              type_legal = (addr_lo == 2'b00);
      RT_BYTE_U, RT_BYTE_S: type_legal = 1'b1;
      RT_HALF_U, RT_HALF_S: type_legal = ~addr_lo[0];
      default:              type_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_ctrl_store_align.sv
// Byte-lane enables and replicated write data from access type and low address bits.
// Purely combinational; no state, no backpressure.
module store_align
  import mem_access_ctrl_pkg::*;
(
  input  logic [2:0]  rtype,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_out
);

  always_comb begin
    be        = 4'b0000;
    wdata_out = 32'h0;
    case (rtype)
      RT_WORD: begin
        be        = 4'b1111;
        wdata_out = wdata;
      end
      RT_BYTE_U, RT_BYTE_S: begin
        be        = 4'b0001 << addr_lo;
        wdata_out = {4{wdata[7:0]}};
      end
      RT_HALF_U, RT_HALF_S: begin
        be        = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_out = {2{wdata[15:0]}};
      end
      default: begin
        be        = 4'b0000;
        wdata_out = 32'h0;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage memory access FSM: one outstanding access; load resp 3 cycles after accept, store 2.
// Pipeline stalls while an access is in flight; memory side uses valid/ready with TIMEOUT abort.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_type,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [2:0]  ext_op,
  output logic [1:0]  ext_a,
  output logic        fault,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_e        state, state_nxt;
  logic          legal;
  logic          accept;
  logic          timeout_hit;
  logic          tmo_flag;
  logic [CW-1:0] tmo_cnt;
  logic          last_cycle;
  logic [3:0]    al_be;
  logic [31:0]   al_wdata;

  assign legal      = type_legal(req_type, req_addr[1:0]);
  assign accept     = (state == S_IDLE) && req_valid && legal;
  assign last_cycle = (tmo_cnt == CW'(TIMEOUT - 1));

  store_align u_store_align (
    .rtype     (req_type),
    .addr_lo   (req_addr[1:0]),
    .wdata     (req_wdata),
    .be        (al_be),
    .wdata_out (al_wdata)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    timeout_hit = 1'b0;
    stall       = 1'b0;
    resp_valid  = 1'b0;
    fault       = 1'b0;
    mem_valid   = 1'b0;
    case (state)
      S_IDLE: begin
        stall = accept;
        fault = req_valid & ~legal;
        if (accept) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        stall     = 1'b1;
        mem_valid = 1'b1;
        // An accepted store completes even on the last budget cycle; an accepted load would not.
        if (mem_ready && mem_we) begin
          state_nxt = S_RESP;
        end else if (last_cycle) begin
          state_nxt   = S_RESP;
          timeout_hit = 1'b1;
        end else if (mem_ready) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        stall = 1'b1;
        if (mem_rvalid) begin
          state_nxt = S_RESP;
        end else if (last_cycle) begin
          state_nxt   = S_RESP;
          timeout_hit = 1'b1;
        end
      end
      S_RESP: begin
        resp_valid = 1'b1;
        fault      = tmo_flag;
        state_nxt  = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_we     <= 1'b0;
      mem_addr   <= 32'h0;
      mem_be     <= 4'b0000;
      mem_wdata  <= 32'h0;
      ext_op     <= 3'd0;
      ext_a      <= 2'd0;
      resp_rdata <= 32'h0;
      tmo_cnt    <= '0;
      tmo_flag   <= 1'b0;
    end else begin
      if (accept) begin
        mem_we     <= req_we;
        mem_addr   <= {req_addr[31:2], 2'b00};
        mem_be     <= al_be;
        mem_wdata  <= al_wdata;
        ext_op     <= req_type;
        ext_a      <= req_addr[1:0];
        resp_rdata <= 32'h0;
        tmo_cnt    <= '0;
        tmo_flag   <= 1'b0;
      end
      if (state == S_ISSUE || state == S_WAIT) tmo_cnt <= tmo_cnt + 1'b1;
      if (state == S_WAIT && mem_rvalid) resp_rdata <= mem_rdata;
      if (timeout_hit) begin
        tmo_flag   <= 1'b1;
        resp_rdata <= 32'h0;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl built with a 4-cycle access budget.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid, req_we;
  logic [2:0]  req_type;
  logic [31:0] req_addr, req_wdata;
  logic        stall, resp_valid, fault, mem_valid, mem_ready, mem_we, mem_rvalid;
  logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  ext_op;
  logic [1:0]  ext_a;
  logic [3:0]  mem_be;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.TIMEOUT(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_type   (req_type),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .stall      (stall),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .ext_op     (ext_op),
    .ext_a      (ext_a),
    .fault      (fault),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; checks run 1ns later, well before the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".stall"},      stall,      0);
    chk({tag, ".resp_valid"}, resp_valid, 0);
    chk({tag, ".fault"},      fault,      0);
    chk({tag, ".mem_valid"},  mem_valid,  0);
    chk({tag, ".mem_we"},     mem_we,     0);
    chk({tag, ".mem_be"},     mem_be,     0);
    chk({tag, ".mem_addr"},   mem_addr,   0);
    chk({tag, ".mem_wdata"},  mem_wdata,  0);
    chk({tag, ".resp_rdata"}, resp_rdata, 0);
    chk({tag, ".ext_op"},     ext_op,     0);
    chk({tag, ".ext_a"},      ext_a,      0);
  endtask

  // Zero-wait store: accept, one ISSUE cycle with mem_ready, RESP two cycles after accept.
  task automatic do_store(input string tag, input logic [2:0] t, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] exp_be,
                          input logic [31:0] exp_wd, input logic [31:0] exp_addr);
    tick();
    req_valid = 1; req_we = 1; req_type = t; req_addr = a; req_wdata = d; mem_ready = 1;
    settle();
    chk({tag, ".accept_stall"}, stall, 1);
    tick();
    settle();
    chk({tag, ".mem_valid"},  mem_valid,  1);
    chk({tag, ".mem_we"},     mem_we,     1);
    chk({tag, ".mem_addr"},   mem_addr,   exp_addr);
    chk({tag, ".mem_be"},     mem_be,     exp_be);
    chk({tag, ".mem_wdata"},  mem_wdata,  exp_wd);
    chk({tag, ".issue_resp"}, resp_valid, 0);
    tick();
    settle();
    chk({tag, ".resp_valid"}, resp_valid, 1);
    chk({tag, ".resp_stall"}, stall,      0);
    chk({tag, ".resp_fault"}, fault,      0);
    chk({tag, ".resp_mvld"},  mem_valid,  0);
    tick();
    req_valid = 0; mem_ready = 0;
    settle();
    chk({tag, ".idle_resp"},  resp_valid, 0);
    chk({tag, ".idle_mvld"},  mem_valid,  0);
  endtask

  initial begin
    reset_n = 0; req_valid = 0; req_we = 0; req_type = 0; req_addr = 0; req_wdata = 0;
    mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
    #2;
    chk_all_zero("reset");
    tick(); tick();
    reset_n = 1;
    settle();
    chk_all_zero("post_reset");

    // lb 0x1003, data returned on the second WAIT cycle
    tick();
    req_valid = 1; req_we = 0; req_type = 3'd2; req_addr = 32'h0000_1003;
    settle();
    chk("lb.accept_stall", stall, 1);
    chk("lb.accept_fault", fault, 0);
    chk("lb.accept_mvld",  mem_valid, 0);
    tick();
    mem_ready = 1;
    settle();
    chk("lb.mem_valid", mem_valid, 1);
    chk("lb.mem_be",    mem_be,    4'b1000);
    chk("lb.mem_addr",  mem_addr,  32'h0000_1000);
    chk("lb.mem_we",    mem_we,    0);
    chk("lb.ext_op",    ext_op,    3'd2);
    chk("lb.ext_a",     ext_a,     2'd3);
    tick();
    mem_ready = 0;
    settle();
    chk("lb.wait1_mvld",  mem_valid, 0);
    chk("lb.wait1_stall", stall, 1);
    chk("lb.wait1_resp",  resp_valid, 0);
    tick();
    mem_rvalid = 1; mem_rdata = 32'h80FF_FF12;
    settle();
    chk("lb.wait2_stall", stall, 1);
    tick();
    mem_rvalid = 0; mem_rdata = 32'h0;
    settle();
    chk("lb.resp_valid", resp_valid, 1);
    chk("lb.resp_rdata", resp_rdata, 32'h80FF_FF12);
    chk("lb.resp_ext_op", ext_op, 3'd2);
    chk("lb.resp_ext_a",  ext_a, 2'd3);
    chk("lb.resp_stall",  stall, 0);
    chk("lb.resp_fault",  fault, 0);
    tick();
    req_valid = 0;
    settle();
    chk("lb.pulse_end", resp_valid, 0);
    tick();
    settle();
    chk("lb.no_reissue", mem_valid, 0);

    // lhu 0x3000 with zero-wait memory: resp_valid 3 cycles after accept
    tick();
    req_valid = 1; req_we = 0; req_type = 3'd3; req_addr = 32'h0000_3000; mem_ready = 1;
    tick();
    settle();
    chk("lhu.mem_be", mem_be, 4'b0011);
    chk("lhu.mem_valid", mem_valid, 1);
    tick();
    mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'h0000_CAFE;
    settle();
    chk("lhu.wait_resp", resp_valid, 0);
    tick();
    mem_rvalid = 0;
    settle();
    chk("lhu.resp_valid", resp_valid, 1);
    chk("lhu.resp_rdata", resp_rdata, 32'h0000_CAFE);
    chk("lhu.ext_op", ext_op, 3'd3);
    chk("lhu.ext_a",  ext_a,  2'd0);
    tick();
    req_valid = 0;
    settle();
    chk("lhu.pulse_end", resp_valid, 0);

    do_store("sh", 3'd3, 32'h0000_2002, 32'h0000_BEEF, 4'b1100, 32'hBEEF_BEEF, 32'h0000_2000);
    do_store("sw", 3'd0, 32'h0000_0040, 32'h1234_5678, 4'b1111, 32'h1234_5678, 32'h0000_0040);
    do_store("sb", 3'd1, 32'h0000_0011, 32'h0000_00A5, 4'b0010, 32'hA5A5_A5A5, 32'h0000_0010);

    // illegal requests: fault in the request cycle, no stall, no memory access
    tick();
    req_valid = 1; req_we = 0; req_type = 3'd0; req_addr = 32'h0000_3001; mem_ready = 1;
    settle();
    chk("lw_mis.fault", fault, 1);
    chk("lw_mis.stall", stall, 0);
    chk("lw_mis.mvld",  mem_valid, 0);
    tick();
    settle();
    chk("lw_mis.mvld_next", mem_valid, 0);
    chk("lw_mis.fault_next", fault, 1);
    req_type = 3'd4; req_addr = 32'h0000_0101;
    settle();
    chk("lh_mis.fault", fault, 1);
    chk("lh_mis.stall", stall, 0);
    req_type = 3'd5; req_addr = 32'h0000_0000;
    settle();
    chk("type5.fault", fault, 1);
    req_type = 3'd7;
    settle();
    chk("type7.fault", fault, 1);
    tick();
    settle();
    chk("illegal.mvld", mem_valid, 0);
    req_valid = 0; mem_ready = 0;
    settle();
    chk("illegal.fault_clear", fault, 0);

    // timeout: mem_ready held low for the whole budget of 4 ISSUE cycles
    tick();
    req_valid = 1; req_we = 0; req_type = 3'd0; req_addr = 32'h0000_4000;
    tick();
    settle();
    chk("tmo.issue1", mem_valid, 1);
    tick(); tick(); tick();
    settle();
    chk("tmo.issue4_mvld",  mem_valid, 1);
    chk("tmo.issue4_stall", stall, 1);
    chk("tmo.issue4_resp",  resp_valid, 0);
    tick();
    settle();
    chk("tmo.resp_valid", resp_valid, 1);
    chk("tmo.fault",      fault, 1);
    chk("tmo.rdata",      resp_rdata, 0);
    chk("tmo.mvld",       mem_valid, 0);
    chk("tmo.stall",      stall, 0);
    tick();
    req_valid = 0;
    settle();
    chk("tmo.fault_clear", fault, 0);
    chk("tmo.pulse_end",   resp_valid, 0);

    // reset during WAIT, stray read data afterwards must be ignored
    tick();
    req_valid = 1; req_we = 0; req_type = 3'd0; req_addr = 32'h0000_5000; mem_ready = 1;
    tick();
    tick();
    mem_ready = 0;
    settle();
    chk("rst.in_wait", stall, 1);
    req_valid = 0;
    reset_n = 0;
    settle();
    chk_all_zero("rst_mid");
    tick();
    reset_n = 1;
    tick();
    mem_rvalid = 1; mem_rdata = 32'hDEAD_BEEF;
    settle();
    chk("rst.stray_resp",  resp_valid, 0);
    chk("rst.stray_stall", stall, 0);
    tick();
    mem_rvalid = 0;
    settle();
    chk("rst.after_resp",  resp_valid, 0);
    chk("rst.after_rdata", resp_rdata, 0);
    tick();
    settle();
    chk("rst.idle_resp", resp_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
